// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Purpose  : Samples a multiplexed active-low seven-segment bus and rebuilds
//            the displayed BCD digits, decimal points and per-digit errors.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              segs_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    stale
);

    localparam int unsigned c_STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned c_BUS_W  = 8 + NUM_DIGITS;

    localparam logic [c_STAB_W-1:0]   c_STAB_MAX = c_STAB_W'(STABLE_CYCLES);
    localparam logic [c_STAB_W-1:0]   c_STAB_HIT = c_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [c_STAB_W-1:0]   c_STAB_ONE = c_STAB_W'(1);
    localparam logic [c_TO_W-1:0]     c_TO_MAX   = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0]     c_TO_ONE   = c_TO_W'(1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);

    logic [7:0]              r_segs_m, r_segs_s;
    logic [NUM_DIGITS-1:0]   r_an_m, r_an_s;
    logic [c_BUS_W-1:0]      r_prev;
    logic [c_STAB_W-1:0]     r_stab_cnt;
    logic [c_TO_W-1:0]       r_to_cnt;
    logic [4*NUM_DIGITS-1:0] r_stg_val, r_value;
    logic [NUM_DIGITS-1:0]   r_stg_dp, r_stg_err, r_seen;
    logic [NUM_DIGITS-1:0]   r_dp, r_err;
    logic                    r_fv, r_stale;

    logic [c_BUS_W-1:0]      w_bus;
    logic                    w_diff, w_strobe, w_onehot, w_cap, w_frame;
    logic                    w_err, w_dp;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_an_lo, w_seen_nxt;
    logic [4*NUM_DIGITS-1:0] w_stg_val;
    logic [NUM_DIGITS-1:0]   w_stg_dp, w_stg_err;
    logic [c_TO_W-1:0]       w_to_nxt;

    // Returns {err, nibble}; blank reads as F without an error.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   f_decode = {1'b0, 4'h0};
            7'h79:   f_decode = {1'b0, 4'h1};
            7'h24:   f_decode = {1'b0, 4'h2};
            7'h30:   f_decode = {1'b0, 4'h3};
            7'h19:   f_decode = {1'b0, 4'h4};
            7'h12:   f_decode = {1'b0, 4'h5};
            7'h02:   f_decode = {1'b0, 4'h6};
            7'h78:   f_decode = {1'b0, 4'h7};
            7'h00:   f_decode = {1'b0, 4'h8};
            7'h18:   f_decode = {1'b0, 4'h9};
            7'h7F:   f_decode = {1'b0, 4'hF};
            default: f_decode = {1'b1, 4'hF};
        endcase
    endfunction

    // Idle bus is all-ones, so the synchronizers reset there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_segs_m <= '1;
            r_segs_s <= '1;
            r_an_m   <= '1;
            r_an_s   <= '1;
        end else begin
            r_segs_m <= segs_in;
            r_segs_s <= r_segs_m;
            r_an_m   <= an_in;
            r_an_s   <= r_an_m;
        end
    end

    assign w_bus    = {r_segs_s, r_an_s};
    assign w_diff   = (w_bus != r_prev);
    assign w_strobe = !w_diff && (r_stab_cnt == c_STAB_HIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '1;
            r_stab_cnt <= '0;
        end else begin
            r_prev <= w_bus;
            if (w_diff)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != c_STAB_MAX)
                r_stab_cnt <= r_stab_cnt + c_STAB_ONE;
        end
    end

    // Only a single active anode identifies a digit; anything else is ignored.
    assign w_an_lo  = ~r_an_s;
    assign w_onehot = (w_an_lo != '0) && ((w_an_lo & (w_an_lo - c_AN_ONE)) == '0);
    assign w_cap    = w_strobe && w_onehot;
    assign {w_err, w_nib} = f_decode(r_segs_s[6:0]);
    assign w_dp     = ~r_segs_s[7];

    always_comb begin
        w_stg_val = r_stg_val;
        w_stg_dp  = r_stg_dp;
        w_stg_err = r_stg_err;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_cap && w_an_lo[i]) begin
                w_stg_val[4*i +: 4] = w_nib;
                w_stg_dp[i]         = w_dp;
                w_stg_err[i]        = w_err;
            end
        end
    end

    assign w_seen_nxt = r_seen | (w_cap ? w_an_lo : '0);
    assign w_frame    = w_cap && (&w_seen_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_val <= '0;
            r_stg_dp  <= '0;
            r_stg_err <= '0;
            r_seen    <= '0;
            r_value   <= '0;
            r_dp      <= '0;
            r_err     <= '0;
            r_fv      <= 1'b0;
        end else begin
            r_stg_val <= w_stg_val;
            r_stg_dp  <= w_stg_dp;
            r_stg_err <= w_stg_err;
            r_fv      <= w_frame;
            if (w_frame) begin
                r_value <= w_stg_val;
                r_dp    <= w_stg_dp;
                r_err   <= w_stg_err;
                r_seen  <= '0;
            end else begin
                r_seen  <= w_seen_nxt;
            end
        end
    end

    // A capture resets the count, so it always beats a coincident timeout.
    always_comb begin
        w_to_nxt = r_to_cnt;
        if (w_cap)
            w_to_nxt = '0;
        else if (r_to_cnt != c_TO_MAX)
            w_to_nxt = r_to_cnt + c_TO_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_stale  <= 1'b0;
        end else begin
            r_to_cnt <= w_to_nxt;
            r_stale  <= (w_to_nxt == c_TO_MAX);
        end
    end

    assign value       = r_value;
    assign dp_out      = r_dp;
    assign digit_err   = r_err;
    assign frame_valid = r_fv;
    assign stale       = r_stale;

endmodule
`default_nettype wire
